// File: rtl/vga_timing_scheduler_if.sv
// vga_timing_scheduler_if: update-window access bundle
// requesters drive req, the scheduler answers with grant
interface vga_timing_scheduler_if;
   logic [1:0] req;
   logic [1:0] grant;

   modport master (
      output req,
      input  grant
   );

   modport slave (
      input  req,
      output grant
   );
endinterface

// File: rtl/vga_timing_scheduler.sv
// vga_timing_scheduler: VGA counters, sync/blank decode and
// round-robin arbitration of the vertical-blanking update window
module vga_timing_scheduler #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       pixel_clk,
   input  logic       reset,
   input  logic       enable,
   output logic [9:0] h_count,
   output logic [9:0] v_count,
   output logic       hsync,
   output logic       vsync,
   output logic       video_active,
   output logic       line_start,
   output logic       frame_start,
   output logic       update_window,
   vga_timing_scheduler_if.slave arb
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   typedef enum logic [1:0] {
      IDLE,
      GRANT0,
      GRANT1
   } arb_state_t;

   logic       h_wrap;
   logic [9:0] h_nxt;
   logic [9:0] v_nxt;
   logic       hs_nxt;
   logic       vs_nxt;
   logic       va_nxt;
   logic       win_nxt;

   arb_state_t state;
   arb_state_t state_nxt;
   logic       last_served;
   logic       served_nxt;

   // next counts; out-of-range values collapse to zero
   always_comb begin
      h_wrap = (h_count >= H_LAST);
      h_nxt  = h_wrap ? 10'd0 : h_count + 10'd1;
      if (v_count > V_LAST) begin
         v_nxt = 10'd0;
      end else if (h_wrap) begin
         v_nxt = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
      end else begin
         v_nxt = v_count;
      end
   end

   // decode from next counts so outputs line up with the counts
   always_comb begin
      hs_nxt  = !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
      vs_nxt  = !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
      va_nxt  = (h_nxt < H_VIS) && (v_nxt < V_VIS);
      win_nxt = enable ? (v_nxt >= V_VIS) : update_window;
   end

   // counter and timing output registers
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         h_count       <= 10'd0;
         v_count       <= 10'd0;
         hsync         <= 1'b1;
         vsync         <= 1'b1;
         video_active  <= 1'b1;
         line_start    <= 1'b0;
         frame_start   <= 1'b0;
         update_window <= 1'b0;
      end else if (enable) begin
         h_count       <= h_nxt;
         v_count       <= v_nxt;
         hsync         <= hs_nxt;
         vsync         <= vs_nxt;
         video_active  <= va_nxt;
         line_start    <= h_wrap;
         frame_start   <= h_wrap && (v_nxt == 10'd0);
         update_window <= win_nxt;
      end else begin
         line_start    <= 1'b0;
         frame_start   <= 1'b0;
      end
   end

   // arbiter state and round-robin history
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         state       <= IDLE;
         last_served <= 1'b1;
      end else begin
         state       <= state_nxt;
         last_served <= served_nxt;
      end
   end

   // arbiter next state; the window check looks one cycle ahead
   // so a holder loses grant in the very cycle v_count reads 0
   always_comb begin
      state_nxt  = state;
      served_nxt = last_served;
      unique case (state)
         IDLE: begin
            if (update_window && win_nxt && enable) begin
               if (arb.req[0] && (!arb.req[1] || last_served)) begin
                  state_nxt  = GRANT0;
                  served_nxt = 1'b0;
               end else if (arb.req[1]) begin
                  state_nxt  = GRANT1;
                  served_nxt = 1'b1;
               end
            end
         end
         GRANT0: begin
            if (!win_nxt) begin
               state_nxt = IDLE;
            end else if (!arb.req[0]) begin
               if (arb.req[1] && enable) begin
                  state_nxt  = GRANT1;
                  served_nxt = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         GRANT1: begin
            if (!win_nxt) begin
               state_nxt = IDLE;
            end else if (!arb.req[1]) begin
               if (arb.req[0] && enable) begin
                  state_nxt  = GRANT0;
                  served_nxt = 1'b0;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign arb.grant = {state == GRANT1, state == GRANT0};

endmodule

// File: tb/tb_vga_timing_scheduler.sv
// tb_vga_timing_scheduler: directed checks of counters, sync
// decode, pulses and window arbitration (full and small geometry)
module tb_vga_timing_scheduler;

   logic pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic       rst_big, en_big;
   logic [9:0] b_h, b_v;
   logic       b_hs, b_vs, b_va, b_ls, b_fs, b_uw;

   logic       rst_sm, en_sm;
   logic [9:0] s_h, s_v;
   logic       s_hs, s_vs, s_va, s_ls, s_fs, s_uw;

   vga_timing_scheduler_if big_if ();
   vga_timing_scheduler_if sm_if ();

   vga_timing_scheduler u_big (
      .pixel_clk     (pixel_clk),
      .reset         (rst_big),
      .enable        (en_big),
      .h_count       (b_h),
      .v_count       (b_v),
      .hsync         (b_hs),
      .vsync         (b_vs),
      .video_active  (b_va),
      .line_start    (b_ls),
      .frame_start   (b_fs),
      .update_window (b_uw),
      .arb           (big_if.slave)
   );

   // 16 x 11 geometry: hsync low h 10..12, vsync low v 7..8,
   // blanking v 6..10, frame = 176 cycles
   vga_timing_scheduler #(
      .H_VISIBLE (8),
      .H_FRONT   (2),
      .H_SYNC    (3),
      .H_BACK    (3),
      .V_VISIBLE (6),
      .V_FRONT   (1),
      .V_SYNC    (2),
      .V_BACK    (2)
   ) u_small (
      .pixel_clk     (pixel_clk),
      .reset         (rst_sm),
      .enable        (en_sm),
      .h_count       (s_h),
      .v_count       (s_v),
      .hsync         (s_hs),
      .vsync         (s_vs),
      .video_active  (s_va),
      .line_start    (s_ls),
      .frame_start   (s_fs),
      .update_window (s_uw),
      .arb           (sm_if.slave)
   );

   task automatic step(input int n);
      repeat (n) @(posedge pixel_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   int fs_cnt, vs_cnt, uw_cnt, hs_cnt;

   initial begin
      rst_big = 1'b1;
      en_big  = 1'b1;
      rst_sm  = 1'b1;
      en_sm   = 1'b1;
      big_if.req = 2'b00;
      sm_if.req  = 2'b00;

      step(3);
      chk("rst_h", 32'(b_h), 0);
      chk("rst_v", 32'(b_v), 0);
      chk("rst_hs", 32'(b_hs), 1);
      chk("rst_vs", 32'(b_vs), 1);
      chk("rst_va", 32'(b_va), 1);
      chk("rst_ls", 32'(b_ls), 0);
      chk("rst_fs", 32'(b_fs), 0);
      chk("rst_uw", 32'(b_uw), 0);
      chk("rst_gnt", 32'(big_if.grant), 0);

      rst_big = 1'b0;
      step(1);
      chk("rel_h", 32'(b_h), 1);
      chk("rel_v", 32'(b_v), 0);
      chk("rel_ls", 32'(b_ls), 0);

      step(638);
      chk("h639", 32'(b_h), 639);
      chk("va639", 32'(b_va), 1);
      step(1);
      chk("va640", 32'(b_va), 0);
      step(15);
      chk("h655", 32'(b_h), 655);
      chk("hs655", 32'(b_hs), 1);
      step(1);
      chk("hs656", 32'(b_hs), 0);
      step(95);
      chk("h751", 32'(b_h), 751);
      chk("hs751", 32'(b_hs), 0);
      step(1);
      chk("hs752", 32'(b_hs), 1);
      step(47);
      chk("h799", 32'(b_h), 799);
      chk("ls799", 32'(b_ls), 0);
      step(1);
      chk("wrap_h", 32'(b_h), 0);
      chk("wrap_v", 32'(b_v), 1);
      chk("wrap_ls", 32'(b_ls), 1);
      chk("wrap_fs", 32'(b_fs), 0);
      chk("wrap_va", 32'(b_va), 1);
      chk("wrap_vs", 32'(b_vs), 1);

      en_big = 1'b0;
      step(1);
      chk("dis_ls", 32'(b_ls), 0);
      chk("dis_h", 32'(b_h), 0);
      step(49);
      chk("dis50_h", 32'(b_h), 0);
      chk("dis50_v", 32'(b_v), 1);
      chk("dis50_ls", 32'(b_ls), 0);
      en_big = 1'b1;
      step(1);
      chk("res_h", 32'(b_h), 1);
      chk("res_v", 32'(b_v), 1);
      chk("res_ls", 32'(b_ls), 0);

      rst_sm = 1'b0;
      step(1);
      chk("s_rel_h", 32'(s_h), 1);
      chk("s_rel_ls", 32'(s_ls), 0);
      fs_cnt = 0;
      vs_cnt = 0;
      uw_cnt = 0;
      hs_cnt = 0;
      for (int i = 2; i <= 176; i++) begin
         step(1);
         if (s_fs) fs_cnt++;
         if (!s_vs) vs_cnt++;
         if (s_uw) uw_cnt++;
         if (!s_hs) hs_cnt++;
      end
      chk("s_fs_cnt", 32'(fs_cnt), 1);
      chk("s_vs_cnt", 32'(vs_cnt), 32);
      chk("s_uw_cnt", 32'(uw_cnt), 80);
      chk("s_hs_cnt", 32'(hs_cnt), 33);
      chk("s_fr_h", 32'(s_h), 0);
      chk("s_fr_v", 32'(s_v), 0);
      chk("s_fr_fs", 32'(s_fs), 1);
      chk("s_fr_ls", 32'(s_ls), 1);

      step(96);
      chk("s_blk_v", 32'(s_v), 6);
      chk("s_blk_uw", 32'(s_uw), 1);
      sm_if.req = 2'b11;
      chk("g_pre", 32'(sm_if.grant), 0);
      step(1);
      chk("g_both", 32'(sm_if.grant), 1);
      sm_if.req = 2'b10;
      step(1);
      chk("g_hand", 32'(sm_if.grant), 2);
      sm_if.req = 2'b00;
      step(1);
      chk("g_idle", 32'(sm_if.grant), 0);

      sm_if.req = 2'b01;
      step(1);
      chk("g_hold", 32'(sm_if.grant), 1);
      step(75);
      chk("eof_v", 32'(s_v), 10);
      chk("eof_h", 32'(s_h), 15);
      chk("eof_g", 32'(sm_if.grant), 1);
      step(1);
      chk("sof_v", 32'(s_v), 0);
      chk("sof_g", 32'(sm_if.grant), 0);
      step(96);
      chk("reopen_g", 32'(sm_if.grant), 0);
      step(1);
      chk("regnt_h", 32'(s_h), 1);
      chk("regnt_g", 32'(sm_if.grant), 1);

      sm_if.req = 2'b00;
      step(1);
      chk("rr_rel", 32'(sm_if.grant), 0);
      sm_if.req = 2'b11;
      step(1);
      chk("rr_g1", 32'(sm_if.grant), 2);
      sm_if.req = 2'b00;
      step(1);
      chk("rr_rel2", 32'(sm_if.grant), 0);
      chk("rr_h", 32'(s_h), 4);

      en_sm = 1'b0;
      sm_if.req = 2'b10;
      step(50);
      chk("frz_h", 32'(s_h), 4);
      chk("frz_v", 32'(s_v), 6);
      chk("frz_g", 32'(sm_if.grant), 0);
      chk("frz_ls", 32'(s_ls), 0);
      en_sm = 1'b1;
      step(1);
      chk("thaw_h", 32'(s_h), 5);
      chk("thaw_g", 32'(sm_if.grant), 2);

      en_sm = 1'b0;
      sm_if.req = 2'b00;
      step(1);
      chk("dis_rel_g", 32'(sm_if.grant), 0);
      chk("dis_rel_h", 32'(s_h), 5);
      en_sm = 1'b1;
      sm_if.req = 2'b10;
      step(1);
      chk("pre_rst_g", 32'(sm_if.grant), 2);
      chk("pre_rst_h", 32'(s_h), 6);

      rst_sm = 1'b1;
      step(1);
      chk("mrst_h", 32'(s_h), 0);
      chk("mrst_v", 32'(s_v), 0);
      chk("mrst_g", 32'(sm_if.grant), 0);
      chk("mrst_uw", 32'(s_uw), 0);
      chk("mrst_ls", 32'(s_ls), 0);
      chk("mrst_va", 32'(s_va), 1);
      chk("mrst_hs", 32'(s_hs), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_scheduler.md
Name: vga_timing_scheduler

Overview:
- Top-level VGA timing controller. Owns the horizontal and vertical pixel counters and sequences them: the horizontal wrap is the vertical advance.
- Decodes sync, blanking and line/frame event pulses from the counters.
- Shares the vertical-blanking update window between two requesters (game-logic and sprite-loader) with a round-robin grant, so framebuffer/sprite state changes only while nothing is being drawn.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BACK, 48, horizontal back porch (H_TOTAL = sum = 800)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BACK, 33, vertical back porch (V_TOTAL = sum = 525)

Ports:
pixel_clk  in  1  pixel clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  advance timing when 1; freeze counters and all timing outputs when 0
h_count  out  10  current pixel column, 0..H_TOTAL-1
v_count  out  10  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
video_active  out  1  1 when h_count < H_VISIBLE and v_count < V_VISIBLE
line_start  out  1  one-cycle pulse when h_count wraps to 0
frame_start  out  1  one-cycle pulse when h_count and v_count both wrap to 0
update_window  out  1  1 while v_count >= V_VISIBLE (vertical blanking)
req  in  2  update-access requests; bit0 game-logic, bit1 sprite-loader
grant  out  2  one-hot or zero access grant

Behaviour:
- Reset values:
  - h_count=0, v_count=0
  - hsync=1, vsync=1, video_active=1
  - line_start=0, frame_start=0, update_window=0
  - grant=00, FSM=IDLE, last_served=1 (req[0] wins the first tie)
- Counters, on each enabled cycle:
  - h_count increments; at H_TOTAL-1 it wraps to 0.
  - v_count increments only on the cycle h_count wraps; at V_TOTAL-1 (with h wrap) it wraps to 0.
  - A count never exceeds its TOTAL-1. Any out-of-range value is forced to 0 on the next enabled cycle.
- Timing outputs:
  - All are registered and computed from next-state counts, so they are valid in the same cycle as the h_count/v_count they describe. Zero extra latency relative to the counts.
  - hsync=0 iff H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC (656..751 default).
  - vsync=0 iff V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC (490..491 default).
- Event pulses:
  - line_start=1 for exactly the one cycle in which h_count becomes 0 via wrap, never from reset.
  - frame_start=1 only when line_start=1 and v_count becomes 0.
- enable=0:
  - Counts, syncs, video_active and update_window hold.
  - line_start and frame_start are forced to 0.
- Arbiter FSM, states IDLE, GRANT0, GRANT1. grant is registered: a request sampled in cycle n yields grant in cycle n+1.
  - IDLE: if update_window=1, enable=1 and req!=0, go to GRANTx.
    - Single requester: grant that one.
    - Both requesting: grant the one that is not last_served.
    - Record last_served on every new grant.
  - GRANTx -> req[x]=0 sampled: release.
    - If the other requester is asserted, window open and enable=1, hand over directly to it (no idle cycle).
    - Otherwise go to IDLE.
  - GRANTx -> window closes (update_window becomes 0 at frame_start): forced release. grant=00 in the same cycle v_count reads 0, regardless of req.
  - While enable=0: no new grant is issued; releases still take effect.
  - A holder keeps grant indefinitely while req held and the window is open.
- Reset mid-frame or mid-grant returns all state to the reset values on the next edge. No pulse is emitted on reset.

Test Plan:
- Assert reset for 3 cycles, then enable=1 -> reset values hold during reset. First cycle after release h_count=1, v_count=0, no line_start.
- Run one line -> hsync low exactly for h_count 656..751. line_start at cycle 800 with v_count=1. video_active falls at h_count=640.
- Run 420000 enabled cycles -> frame_start exactly once. vsync low for v_count 490..491 only. update_window high for v_count 480..524.
- req=11 at v_count=480 -> grant=01 next cycle. Drop req[0] -> grant=10 the following cycle. Drop req[1] -> grant=00, FSM IDLE.
- Hold req=01 through end of frame -> grant=01 until the cycle v_count=0, then grant=00. Re-granted at next v_count=480, h_count=1.
- enable=0 for 50 cycles mid-line with req=10 in blanking -> counts frozen, no pulses, no new grant. Resumes from the same h_count when enable=1.
